// File: rtl/wb_hilo_commit.sv
// rtl/wb_hilo_commit.sv - MEM/WB pipeline register with HI/LO commit and retired-write counter
module wb_hilo_commit #(
  parameter int unsigned CNT_W    = 32,
  parameter logic [4:0]  NOP_ADDR = 5'b00000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       stall,
  input  logic             flush,
  input  logic [31:0]      mem_wdata,
  input  logic [4:0]       mem_wd,
  input  logic             mem_wreg,
  input  logic             mem_whilo,
  input  logic [31:0]      mem_hi,
  input  logic [31:0]      mem_lo,
  output logic [31:0]      wb_wdata,
  output logic [4:0]       wb_wd,
  output logic             wb_wreg,
  output logic             wb_whilo,
  output logic [31:0]      wb_hi,
  output logic [31:0]      wb_lo,
  output logic [31:0]      hi_o,
  output logic [31:0]      lo_o,
  output logic [CNT_W-1:0] retire_cnt
);

  logic wreg_r;
  logic commit_en;
  logic load_bubble;
  logic load_mem;

  assign commit_en   = !stall[5];
  // MEM held with WB free would replay the same instruction, so a bubble goes in instead
  assign load_bubble = flush || (stall[4] && !stall[5]);
  assign load_mem    = !stall[4];

  // A held instruction must not reach the register file until its release cycle
  assign wb_wreg = wreg_r & commit_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wdata <= '0;
      wb_wd    <= NOP_ADDR;
      wreg_r   <= 1'b0;
      wb_whilo <= 1'b0;
      wb_hi    <= '0;
      wb_lo    <= '0;
    end else if (load_bubble) begin
      wb_wdata <= '0;
      wb_wd    <= NOP_ADDR;
      wreg_r   <= 1'b0;
      wb_whilo <= 1'b0;
      wb_hi    <= '0;
      wb_lo    <= '0;
    end else if (load_mem) begin
      wb_wdata <= mem_wdata;
      wb_wd    <= mem_wd;
      wreg_r   <= mem_wreg;
      wb_whilo <= mem_whilo;
      wb_hi    <= mem_hi;
      wb_lo    <= mem_lo;
    end
  end

  // Commit uses the instruction currently in WB, independent of what is loaded behind it
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o       <= '0;
      lo_o       <= '0;
      retire_cnt <= '0;
    end else if (commit_en) begin
      if (wb_whilo) begin
        hi_o <= wb_hi;
        lo_o <= wb_lo;
      end
      if (wreg_r || wb_whilo)
        retire_cnt <= retire_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_hilo_commit.sv
// tb/tb_wb_hilo_commit.sv - directed self-checking bench for wb_hilo_commit
module tb_wb_hilo_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [31:0] wb_wdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] retire_cnt;

  logic [31:0] s_wdata, s_hi, s_lo, s_hi_o, s_lo_o;
  logic [4:0]  s_wd;
  logic        s_wreg, s_whilo;
  logic [3:0]  s_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_hilo_commit dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_wdata(wb_wdata), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_whilo(wb_whilo),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .hi_o(hi_o), .lo_o(lo_o), .retire_cnt(retire_cnt)
  );

  wb_hilo_commit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_wdata(s_wdata), .wb_wd(s_wd), .wb_wreg(s_wreg), .wb_whilo(s_whilo),
    .wb_hi(s_hi), .wb_lo(s_lo), .hi_o(s_hi_o), .lo_o(s_lo_o), .retire_cnt(s_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                       input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
    mem_wreg  = wreg;
    mem_wd    = wd;
    mem_wdata = wdata;
    mem_whilo = whilo;
    mem_hi    = hi;
    mem_lo    = lo;
  endtask

  task automatic bubble_in();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 6'b0; flush = 1'b0;
    drive(1'b1, 5'd31, 32'hDEADBEEF, 1'b1, 32'hCAFEF00D, 32'hBAADC0DE);
    tick(); tick();
    check("rst_wdata", wb_wdata, 32'h0);
    check("rst_wd",    {27'b0, wb_wd}, 32'h0);
    check("rst_wreg",  {31'b0, wb_wreg}, 32'h0);
    check("rst_whilo", {31'b0, wb_whilo}, 32'h0);
    check("rst_hi",    wb_hi, 32'h0);
    check("rst_lo",    wb_lo, 32'h0);
    check("rst_hi_o",  hi_o, 32'h0);
    check("rst_lo_o",  lo_o, 32'h0);
    check("rst_cnt",   retire_cnt, 32'h0);

    // first GPR write after reset
    rst = 1'b0;
    drive(1'b1, 5'd3, 32'h1234, 1'b0, 32'h0, 32'h0);
    tick();
    check("gpr_wd",    {27'b0, wb_wd}, 32'd3);
    check("gpr_wdata", wb_wdata, 32'h1234);
    check("gpr_wreg",  {31'b0, wb_wreg}, 32'd1);
    check("gpr_cnt0",  retire_cnt, 32'd0);
    bubble_in();
    tick();
    check("gpr_cnt1",  retire_cnt, 32'd1);

    // HI/LO commit
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'hAAAA0001, 32'h55550002);
    tick();
    check("hl_wb_hi",  wb_hi, 32'hAAAA0001);
    check("hl_wb_lo",  wb_lo, 32'h55550002);
    check("hl_hi_n1",  hi_o, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    check("hl_hi_n2",  hi_o, 32'hAAAA0001);
    check("hl_lo_n2",  lo_o, 32'h55550002);
    check("hl_cnt",    retire_cnt, 32'd2);
    tick();
    check("hl_hi_keep", hi_o, 32'hAAAA0001);
    check("hl_cnt_keep", retire_cnt, 32'd2);

    // MEM stalled, WB free -> bubble
    stall = 6'b010000;
    drive(1'b1, 5'd7, 32'h77, 1'b0, 32'h0, 32'h0);
    tick();
    check("sb_wreg", {31'b0, wb_wreg}, 32'd0);
    check("sb_wd",   {27'b0, wb_wd}, 32'd0);
    check("sb_cnt",  retire_cnt, 32'd2);
    stall = 6'b0;
    tick();
    check("sb_rel_wd",   {27'b0, wb_wd}, 32'd7);
    check("sb_rel_wreg", {31'b0, wb_wreg}, 32'd1);
    bubble_in();
    tick();
    check("sb_cnt_once", retire_cnt, 32'd3);
    tick();
    check("sb_cnt_stay", retire_cnt, 32'd3);

    // WB hold of a HI/LO write
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h11112222, 32'h33334444);
    tick();
    stall = 6'b110000;
    drive(1'b1, 5'd12, 32'hDEAD, 1'b1, 32'hDEADDEAD, 32'hBEEFBEEF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_wb_hi",  wb_hi, 32'h11112222);
      check("hold_whilo",  {31'b0, wb_whilo}, 32'd1);
      check("hold_wreg",   {31'b0, wb_wreg}, 32'd0);
      check("hold_hi_o",   hi_o, 32'hAAAA0001);
      check("hold_cnt",    retire_cnt, 32'd3);
    end
    stall = 6'b0;
    bubble_in();
    tick();
    check("hold_rel_hi", hi_o, 32'h11112222);
    check("hold_rel_lo", lo_o, 32'h33334444);
    check("hold_rel_cnt", retire_cnt, 32'd4);
    tick();
    check("hold_cnt_once", retire_cnt, 32'd4);

    // flush beats hold on a held GPR write
    drive(1'b1, 5'd9, 32'h99, 1'b0, 32'h0, 32'h0);
    tick();
    stall = 6'b110000;
    tick();
    check("fl_held_wd",   {27'b0, wb_wd}, 32'd9);
    check("fl_held_wreg", {31'b0, wb_wreg}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0; stall = 6'b0;
    bubble_in();
    check("fl_wd",   {27'b0, wb_wd}, 32'd0);
    check("fl_wreg", {31'b0, wb_wreg}, 32'd0);
    check("fl_cnt",  retire_cnt, 32'd4);
    tick();
    check("fl_cnt_after", retire_cnt, 32'd4);

    // back-to-back HI/LO writes
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h00000001, 32'h00000010);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h00000002, 32'h00000020);
    tick();
    check("b2b_hi1", hi_o, 32'h1);
    check("b2b_lo1", lo_o, 32'h10);
    bubble_in();
    tick();
    check("b2b_hi2", hi_o, 32'h2);
    check("b2b_lo2", lo_o, 32'h20);
    check("b2b_cnt", retire_cnt, 32'd6);

    // counter wrap on the 4-bit instance; mid-stall reset discards held state
    stall = 6'b110000;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h0BAD0BAD, 32'h0BAD0BAD);
    tick();
    rst = 1'b1;
    tick();
    check("rst_stall_whilo", {31'b0, wb_whilo}, 32'd0);
    check("rst_stall_hi_o",  hi_o, 32'h0);
    rst = 1'b0; stall = 6'b0;
    drive(1'b1, 5'd1, 32'h1, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 17; i++) tick();
    bubble_in();
    tick();
    check("wrap_cnt4",  {28'b0, s_cnt}, 32'h1);
    check("wrap_cnt32", retire_cnt, 32'd17);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
